screen_rotate_tb3: RTL and testbench

- Rotates or transposes an arcade raster of WIDTH x HEIGHT into a HEIGHT-wide, WIDTH-tall output raster for the scaler input.
- Adds four runtime orientation modes to the CW/CCW-only rotator.
- Uses a triple buffer so the output never reads a buffer that is being written: no tearing and no half-written frames.
- Sits between core video and video_mixer, in the same slot as the existing rotator. Output timing is scaler-only, not a TV/VGA mode.

---
 rtl/screen_rotate_tb3.sv | 186 ++++++++++++++++++
 tb/tb_screen_rotate_tb3.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/screen_rotate_tb3.sv
// Rotating/transposing frame buffer between a core's raster and the scaler input.
// Three buffers (write, ready, shown) keep the reader off any frame still being written.
module screen_rotate_tb3 #(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240,
    parameter int DEPTH  = 8,
    parameter int MARGIN = 4,
    parameter int HTAIL  = 17,
    parameter int VTAIL  = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic [DEPTH-1:0] video_in,
    input  logic             hblank,
    input  logic             vblank,
    input  logic [1:0]       mode,
    input  logic             ce_out,
    output logic [DEPTH-1:0] video_out,
    output logic             hsync,
    output logic             vsync,
    output logic             hblank_out,
    output logic             vblank_out,
    output logic             frame_drop
);
    localparam int FRAME_WORDS = WIDTH * HEIGHT;
    localparam int AW       = $clog2(3 * FRAME_WORDS);
    localparam int XW       = $clog2(WIDTH + 1);
    localparam int YW       = $clog2(HEIGHT + 1);
    localparam int XO_TOTAL = HEIGHT + HTAIL;
    localparam int YO_TOTAL = 2 * MARGIN + WIDTH + VTAIL;
    localparam int XOW      = $clog2(XO_TOTAL);
    localparam int YOW      = $clog2(YO_TOTAL);

    localparam logic [AW-1:0]  FRAME_A  = AW'(FRAME_WORDS);
    localparam logic [AW-1:0]  HEIGHT_A = AW'(HEIGHT);
    localparam logic [XW-1:0]  X_LIM    = XW'(WIDTH);
    localparam logic [XW-1:0]  X_LAST   = XW'(WIDTH - 1);
    localparam logic [YW-1:0]  Y_LIM    = YW'(HEIGHT);
    localparam logic [YW-1:0]  Y_LAST   = YW'(HEIGHT - 1);
    localparam logic [XOW-1:0] XO_ACT   = XOW'(HEIGHT);
    localparam logic [XOW-1:0] XO_LAST  = XOW'(XO_TOTAL - 1);
    localparam logic [XOW-1:0] HS_ON    = XOW'(HEIGHT + 8);
    localparam logic [XOW-1:0] HS_OFF   = XOW'(HEIGHT + 10);
    localparam logic [YOW-1:0] YO_TOP   = YOW'(MARGIN);
    localparam logic [YOW-1:0] YO_BOT   = YOW'(MARGIN + WIDTH);
    localparam logic [YOW-1:0] YO_VBL   = YOW'(2 * MARGIN + WIDTH);
    localparam logic [YOW-1:0] VS_A     = YOW'(2 * MARGIN + WIDTH + 10);
    localparam logic [YOW-1:0] VS_B     = YOW'(2 * MARGIN + WIDTH + 11);
    localparam logic [YOW-1:0] YO_LAST  = YOW'(YO_TOTAL - 1);

    logic [DEPTH-1:0] mem [0:3*FRAME_WORDS-1];
    logic [DEPTH-1:0] rd_data;

    // Write side state
    logic          blank_prev, vblank_prev, wr_en;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [1:0]    mode_q;
    logic [1:0]    wbuf, rbuf, ready;
    logic          ready_valid, shown_valid;

    // Read side state
    logic [XOW-1:0] xo;
    logic [YOW-1:0] yo;
    logic           s1_active, s1_hb, s1_vb, s1_hs, s1_vs;

    logic          blank, vb_rise, blank_rise, handover, frame_start, take;
    logic          ready_eff_valid, shown_eff, wr_do, active;
    logic [1:0]    ready_eff, rd_buf;
    logic [XW-1:0] wv;
    logic [YW-1:0] wu;
    logic [YOW-1:0] rd_v;
    logic [AW-1:0] wr_addr, rd_addr;

    always_comb begin
        blank      = hblank | vblank;
        vb_rise    = vblank & ~vblank_prev;
        blank_rise = blank & ~blank_prev;
        // The very first vblank after reset only arms writing; nothing is handed over.
        handover   = vb_rise & wr_en;

        wu = y;
        wv = x;
        case (mode_q)
            2'd0:    begin wu = Y_LAST - y; wv = x;          end
            2'd1:    begin wu = y;          wv = X_LAST - x; end
            2'd2:    begin wu = y;          wv = x;          end
            default: begin wu = Y_LAST - y; wv = X_LAST - x; end
        endcase
        wr_do   = ce & ~blank & wr_en & (x < X_LIM) & (y < Y_LIM);
        wr_addr = AW'(wbuf) * FRAME_A + AW'(wv) * HEIGHT_A + AW'(wu);

        // A handover on the same clk as an output frame start is seen by the reader.
        ready_eff_valid = handover | ready_valid;
        ready_eff       = handover ? wbuf : ready;
        frame_start     = ce_out & (xo == '0) & (yo == '0);
        take            = frame_start & ready_eff_valid;
        rd_buf          = take ? ready_eff : rbuf;
        shown_eff       = shown_valid | take;

        active  = (xo < XO_ACT) & (yo >= YO_TOP) & (yo < YO_BOT);
        rd_v    = yo - YO_TOP;
        rd_addr = active ? (AW'(rd_buf) * FRAME_A + AW'(rd_v) * HEIGHT_A + AW'(xo)) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blank_prev  <= 1'b0;
            vblank_prev <= 1'b0;
            wr_en       <= 1'b0;
            x           <= '0;
            y           <= '0;
            mode_q      <= 2'd0;
            wbuf        <= 2'd0;
            rbuf        <= 2'd1;
            ready       <= 2'd0;
            ready_valid <= 1'b0;
            shown_valid <= 1'b0;
            frame_drop  <= 1'b0;
        end else begin
            blank_prev  <= blank;
            vblank_prev <= vblank;
            frame_drop  <= handover & ready_valid;
            if (vb_rise) begin
                wr_en  <= 1'b1;
                mode_q <= mode;
                x      <= '0;
                y      <= '0;
            end else if (blank_rise) begin
                x <= '0;
                if (y != Y_LIM) y <= y + YW'(1);
            end else if (ce && !blank && x != X_LIM) begin
                x <= x + XW'(1);
            end
            // Indices always sum to 3 when distinct, so this picks the free buffer.
            if (handover) wbuf <= 2'd3 - rbuf - wbuf;
            ready       <= ready_eff;
            ready_valid <= ready_eff_valid & ~take;
            if (take) begin
                rbuf        <= ready_eff;
                shown_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_do)  mem[wr_addr] <= video_in;
        if (ce_out) rd_data <= mem[rd_addr];
    end

    // Two-beat output pipeline: stage 1 = RAM read + timing flags, stage 2 = outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xo         <= '0;
            yo         <= '0;
            s1_active  <= 1'b0;
            s1_hb      <= 1'b1;
            s1_vb      <= 1'b1;
            s1_hs      <= 1'b0;
            s1_vs      <= 1'b0;
            video_out  <= '0;
            hblank_out <= 1'b1;
            vblank_out <= 1'b1;
            hsync      <= 1'b0;
            vsync      <= 1'b0;
        end else if (ce_out) begin
            if (xo == XO_LAST) begin
                xo <= '0;
                yo <= (yo == YO_LAST) ? '0 : yo + YOW'(1);
            end else begin
                xo <= xo + XOW'(1);
            end
            s1_active  <= active & shown_eff;
            s1_hb      <= (xo >= XO_ACT);
            s1_vb      <= (yo >= YO_VBL);
            s1_hs      <= (xo >= HS_ON) & (xo < HS_OFF);
            s1_vs      <= (yo == VS_A) | (yo == VS_B);
            video_out  <= s1_active ? rd_data : '0;
            hblank_out <= s1_hb;
            vblank_out <= s1_vb;
            hsync      <= s1_hs;
            vsync      <= s1_vs;
        end
    end
endmodule

// File: tb/tb_screen_rotate_tb3.sv
// Randomized bench for screen_rotate_tb3: source frames are rotated by a frame-level
// model that tracks which complete frame is pending and which is on screen.
module tb_screen_rotate_tb3;
    localparam int W  = 8;
    localparam int H  = 4;
    localparam int D  = 8;
    localparam int M  = 4;
    localparam int HT = 12;
    localparam int VT = 14;
    localparam int XT = H + HT;
    localparam int YT = 2 * M + W + VT;
    localparam int OF = XT * YT;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         ce = 1'b0;
    logic         hblank = 1'b0;
    logic         vblank = 1'b0;
    logic         ce_out = 1'b0;
    logic [D-1:0] video_in = '0;
    logic [1:0]   mode = 2'd0;
    logic [D-1:0] video_out;
    logic         hsync, vsync, hblank_out, vblank_out, frame_drop;

    screen_rotate_tb3 #(
        .WIDTH(W), .HEIGHT(H), .DEPTH(D), .MARGIN(M), .HTAIL(HT), .VTAIL(VT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ce(ce), .video_in(video_in),
        .hblank(hblank), .vblank(vblank), .mode(mode), .ce_out(ce_out),
        .video_out(video_out), .hsync(hsync), .vsync(vsync),
        .hblank_out(hblank_out), .vblank_out(vblank_out), .frame_drop(frame_drop)
    );

    always #5 clk = ~clk;

    typedef logic [D-1:0] img_t [W][H];
    typedef logic [D-1:0] src_t [H][W];
    typedef struct packed { logic hb; logic vb; logic [D-1:0] pix; } sym_t;
    typedef struct { logic [D-1:0] pix; logic hs, vs, hb, vb; int px, py; } beat_t;

    src_t  cur_src;
    img_t  pend_img, shown_img, cap_img;
    bit    m_en, m_pvb, m_pbl, pend_valid, shown_valid, exp_drop;
    int    m_x, m_y, m_xo, m_yo;
    logic [1:0] m_mode;
    beat_t pipe1, pipe2;
    sym_t  src_q[$];

    int ce_pct = 100, ce_out_pct = 100, vbl_min = 20, vbl_max = 20;
    bit pattern = 1'b0, src_hold = 1'b1, rand_mode = 1'b0, capture = 1'b0, counting = 1'b0;
    int n_checks = 0, n_pass = 0;
    int cnt_hb = 0, cnt_hs = 0, cnt_vs = 0, cnt_vb = 0, cnt_vid = 0;
    int exp_row0 [4][4] = '{'{24, 16, 8, 0}, '{7, 15, 23, 31}, '{0, 8, 16, 24}, '{31, 23, 15, 7}};
    int exp_row7 [4]    = '{31, 23, 15, 7};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic beat_t idle_beat();
        beat_t b;
        b.pix = '0; b.hs = 1'b0; b.vs = 1'b0; b.hb = 1'b1; b.vb = 1'b1; b.px = -1; b.py = -1;
        return b;
    endfunction

    task automatic model_reset();
        m_en = 0; m_pvb = 0; m_pbl = 0; m_x = 0; m_y = 0; m_mode = 2'd0;
        pend_valid = 0; shown_valid = 0; exp_drop = 0; m_xo = 0; m_yo = 0;
        pipe1 = idle_beat(); pipe2 = idle_beat();
    endtask

    task automatic gen_frame();
        sym_t s;
        int lines, npx, nhb, vbl;
        lines = H + ((!pattern && $urandom_range(0, 3) == 0) ? 1 : 0);
        for (int y = 0; y < lines; y++) begin
            npx = W + (pattern ? 0 : $urandom_range(0, 2));
            for (int x = 0; x < npx; x++) begin
                s.hb = 1'b0; s.vb = 1'b0;
                s.pix = pattern ? D'(y * W + x) : D'($urandom);
                src_q.push_back(s);
            end
            nhb = $urandom_range(2, 4);
            for (int k = 0; k < nhb; k++) begin
                s.hb = 1'b1; s.vb = 1'b0; s.pix = '0;
                src_q.push_back(s);
            end
        end
        vbl = $urandom_range(vbl_min, vbl_max);
        for (int k = 0; k < vbl; k++) begin
            s.hb = 1'b1; s.vb = 1'b1; s.pix = '0;
            src_q.push_back(s);
        end
    endtask

    task automatic drive_inputs();
        sym_t s;
        ce_out = ($urandom_range(1, 100) <= ce_out_pct);
        if (rand_mode && $urandom_range(1, 500) == 1) mode = 2'($urandom_range(0, 3));
        if (src_hold) begin
            ce = 1'b0; hblank = 1'b0; vblank = 1'b0; video_in = D'($urandom);
        end else if ($urandom_range(1, 100) <= ce_pct) begin
            if (src_q.size() == 0) gen_frame();
            s = src_q.pop_front();
            ce = 1'b1; hblank = s.hb; vblank = s.vb; video_in = s.pix;
        end else begin
            ce = 1'b0; video_in = D'($urandom);
        end
    endtask

    // Effects of the coming clock edge, in the order the source and display rules state them.
    task automatic model_update();
        bit blank;
        beat_t b;
        int u, v;
        exp_drop = 0;
        blank = hblank | vblank;
        if (vblank && !m_pvb) begin
            if (m_en) begin
                exp_drop = pend_valid;
                for (int sy = 0; sy < H; sy++)
                    for (int sx = 0; sx < W; sx++) begin
                        u = (m_mode == 2'd0 || m_mode == 2'd3) ? H - 1 - sy : sy;
                        v = (m_mode == 2'd1 || m_mode == 2'd3) ? W - 1 - sx : sx;
                        pend_img[v][u] = cur_src[sy][sx];
                    end
                pend_valid = 1;
            end
            m_en = 1; m_mode = mode; m_x = 0; m_y = 0;
        end else if (blank && !m_pbl) begin
            m_x = 0; m_y++;
        end else if (ce && !blank) begin
            if (m_en && m_x < W && m_y < H) cur_src[m_y][m_x] = video_in;
            m_x++;
        end
        m_pvb = vblank; m_pbl = blank;
        if (ce_out) begin
            if (m_xo == 0 && m_yo == 0 && pend_valid) begin
                shown_img = pend_img; shown_valid = 1; pend_valid = 0;
            end
            b.px = m_xo; b.py = m_yo;
            b.hb = (m_xo >= H);
            b.vb = (m_yo >= 2 * M + W);
            b.hs = (m_xo >= H + 8 && m_xo < H + 10);
            b.vs = (m_yo == 2 * M + W + 10 || m_yo == 2 * M + W + 11);
            b.pix = (shown_valid && m_xo < H && m_yo >= M && m_yo < M + W) ? shown_img[m_yo - M][m_xo] : '0;
            pipe2 = pipe1; pipe1 = b;
            m_xo++;
            if (m_xo == XT) begin
                m_xo = 0; m_yo++;
                if (m_yo == YT) m_yo = 0;
            end
        end
    endtask

    task automatic check_outputs();
        check("video_out", video_out, pipe2.pix);
        check("hsync", hsync, pipe2.hs);
        check("vsync", vsync, pipe2.vs);
        check("hblank_out", hblank_out, pipe2.hb);
        check("vblank_out", vblank_out, pipe2.vb);
        check("frame_drop", frame_drop, exp_drop);
        if (capture && pipe2.px >= 0 && pipe2.px < H && pipe2.py >= M && pipe2.py < M + W)
            cap_img[pipe2.py - M][pipe2.px] = video_out;
        if (counting) begin
            cnt_hb += int'(hblank_out); cnt_hs += int'(hsync); cnt_vs += int'(vsync);
            cnt_vb += int'(vblank_out); cnt_vid += (video_out != '0) ? 1 : 0;
        end
    endtask

    // Starts and ends on a falling clock edge.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            drive_inputs();
            model_update();
            @(posedge clk);
            #1;
            check_outputs();
            @(negedge clk);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_video_out"}, video_out, 0);
        check({tag, "_hsync"}, hsync, 0);
        check({tag, "_vsync"}, vsync, 0);
        check({tag, "_hblank_out"}, hblank_out, 1);
        check({tag, "_vblank_out"}, vblank_out, 1);
        check({tag, "_frame_drop"}, frame_drop, 0);
    endtask

    task automatic mid_reset();
        #2 rst_n = 1'b0;
        #1 check_reset_values("async_rst");
        @(posedge clk);
        @(posedge clk);
        #1 check_reset_values("held_rst");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // No source vblank yet: display must stay black while timing runs.
        src_hold = 1'b1; ce_out_pct = 100;
        run(10);
        counting = 1'b1;
        run(OF);
        counting = 1'b0;
        check("blank_frame_hblank_beats", cnt_hb, HT * YT);
        check("blank_frame_hsync_beats", cnt_hs, 2 * YT);
        check("blank_frame_vsync_beats", cnt_vs, 2 * XT);
        check("blank_frame_vblank_beats", cnt_vb, VT * XT);
        check("blank_frame_nonzero_video", cnt_vid, 0);

        // Directed ramp pattern through each orientation.
        src_hold = 1'b0; pattern = 1'b1; ce_pct = 100; vbl_min = 20; vbl_max = 20;
        for (int m = 0; m < 4; m++) begin
            mode = 2'(m);
            run(3 * OF);
            capture = 1'b1;
            run(OF);
            capture = 1'b0;
            for (int u = 0; u < H; u++)
                check($sformatf("mode%0d_row0_u%0d", m, u), cap_img[0][u], exp_row0[m][u]);
            if (m == 0)
                for (int u = 0; u < H; u++)
                    check($sformatf("mode0_row7_u%0d", u), cap_img[W - 1][u], exp_row7[u]);
        end

        // Random pixels, enables, blank lengths and mid-frame mode changes.
        pattern = 1'b0; rand_mode = 1'b1;
        for (int seg = 0; seg < 14; seg++) begin
            ce_pct     = $urandom_range(40, 100);
            ce_out_pct = $urandom_range(30, 100);
            case (seg % 3)
                0:       begin vbl_min = 2;   vbl_max = 30;  end
                1:       begin vbl_min = 200; vbl_max = 700; end
                default: begin vbl_min = 10;  vbl_max = 200; end
            endcase
            if (seg == 7) mid_reset();
            run(1500);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
